// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Boot-time loader that copies a program from a byte stream into
//            the byte-addressed instruction memory, verifies an 8-bit
//            checksum, and then releases the core through cpu_run.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            start, load_len       - begin a load of load_len program bytes
//            abort                 - return to IDLE from any state
//            s_valid/s_data/s_ready- incoming byte stream handshake
//            mem_we/mem_waddr/mem_wdata - instruction memory byte write port
//            cpu_run               - core enable (PC held at 0 while low)
//            busy, done, error     - status (done is a one-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int MEM_BYTES = 100,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [7:0]       mem_wdata,
    output logic             cpu_run,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_RUN   = 3'd3;
    localparam logic [2:0] c_ERROR = 3'd4;

    localparam logic [LEN_W-1:0] c_MEM_BYTES = LEN_W'(MEM_BYTES);
    localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_sum;

    logic [2:0]       w_state;
    logic [LEN_W-1:0] w_count;
    logic [LEN_W-1:0] w_len;
    logic [7:0]       w_sum;
    logic             w_we;
    logic [31:0]      w_waddr;
    logic [7:0]       w_wdata;
    logic             w_done;
    logic             w_hs;
    logic             w_len_bad;
    logic [7:0]       w_sum_chk;

    // s_ready is itself registered from the state, so the handshake reflects
    // what the block advertised during this cycle.
    assign w_hs      = s_valid && s_ready;
    assign w_len_bad = (load_len == '0) || (load_len > c_MEM_BYTES);
    assign w_sum_chk = r_sum + s_data;

    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_len   = r_len;
        w_sum   = r_sum;
        w_we    = 1'b0;
        w_waddr = mem_waddr;
        w_wdata = mem_wdata;
        w_done  = 1'b0;

        if (abort) begin
            // Abort outranks everything, including start and a pending write.
            w_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_RUN, c_ERROR: begin
                    if (start) begin
                        if (w_len_bad) begin
                            w_state = c_ERROR;
                        end else begin
                            w_state = c_LOAD;
                            w_count = '0;
                            w_sum   = '0;
                            w_len   = load_len;
                        end
                    end
                end
                c_LOAD: begin
                    if (w_hs) begin
                        w_we    = 1'b1;
                        w_waddr = {{(32-LEN_W){1'b0}}, r_count};
                        w_wdata = s_data;
                        w_count = r_count + c_ONE;
                        w_sum   = w_sum_chk;
                        if (r_count == r_len - c_ONE) begin
                            w_state = c_CHECK;
                        end
                    end
                end
                c_CHECK: begin
                    // The checksum byte only feeds the compare; it is never written.
                    if (w_hs) begin
                        if (w_sum_chk == 8'h00) begin
                            w_state = c_RUN;
                            w_done  = 1'b1;
                        end else begin
                            w_state = c_ERROR;
                        end
                    end
                end
                default: w_state = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_count   <= '0;
            r_len     <= '0;
            r_sum     <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_len     <= w_len;
            r_sum     <= w_sum;
            mem_we    <= w_we;
            mem_waddr <= w_waddr;
            mem_wdata <= w_wdata;
            done      <= w_done;
            // Status outputs are decoded from the next state so they line up
            // with the state they describe.
            s_ready   <= (w_state == c_LOAD) || (w_state == c_CHECK);
            busy      <= (w_state == c_LOAD) || (w_state == c_CHECK);
            cpu_run   <= (w_state == c_RUN);
            error     <= (w_state == c_ERROR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed self-checking bench for imem_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_boot_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] load_len;
    logic        abort;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        error;

    int total;
    int bad;

    imem_boot_loader #(.MEM_BYTES(100), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        start = 1'b1; load_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1; s_data = b;
        tick();
        s_valid = 1'b0; s_data = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({s_ready, mem_we, cpu_run, busy, done, error, mem_waddr, mem_wdata} !== 46'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {s_ready, mem_we, cpu_run, busy, done, error, mem_waddr, mem_wdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_load();
        logic [7:0] prog [4];
        prog[0] = 8'h34; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h0B;
        do_start(16'd4);
        total++;
        if ({busy, s_ready, cpu_run, mem_we} !== 4'b1100) begin
            bad++; $display("FAIL good_enter_load got=%b exp=1100", {busy, s_ready, cpu_run, mem_we});
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(prog[i]);
            total++;
            if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'(i), prog[i]}) begin
                bad++; $display("FAIL good_write%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, mem_we, mem_waddr, mem_wdata, i, prog[i]);
            end
        end
        send_byte(8'hB9);
        total++;
        if ({done, cpu_run, error, mem_we, s_ready, busy} !== 6'b110000) begin
            bad++; $display("FAIL good_run_entry got=%b exp=110000", {done, cpu_run, error, mem_we, s_ready, busy});
        end
        s_valid = 1'b1; s_data = 8'h77;
        tick();
        s_valid = 1'b0;
        total++;
        if ({done, cpu_run, mem_we, s_ready} !== 4'b0100) begin
            bad++; $display("FAIL good_run_hold got=%b exp=0100", {done, cpu_run, mem_we, s_ready});
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] prog [4];
        prog[0] = 8'h34; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h0B;
        // Starting from RUN must drop cpu_run at this edge.
        do_start(16'd4);
        total++;
        if ({cpu_run, busy} !== 2'b01) begin
            bad++; $display("FAIL start_from_run got=%b exp=01", {cpu_run, busy});
        end
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        send_byte(8'hB8);
        total++;
        if ({error, cpu_run, done, mem_we, s_ready, busy} !== 6'b100000) begin
            bad++; $display("FAIL bad_cksum got=%b exp=100000", {error, cpu_run, done, mem_we, s_ready, busy});
        end
        tick();
        total++;
        if ({error, done, cpu_run} !== 3'b100) begin
            bad++; $display("FAIL bad_cksum_hold got=%b exp=100", {error, done, cpu_run});
        end
    endtask

    task automatic test_length();
        do_start(16'd0);
        total++;
        if ({error, s_ready, mem_we, busy} !== 4'b1000) begin
            bad++; $display("FAIL len_zero got=%b exp=1000", {error, s_ready, mem_we, busy});
        end
        do_start(16'd101);
        total++;
        if ({error, s_ready, mem_we, busy} !== 4'b1000) begin
            bad++; $display("FAIL len_101 got=%b exp=1000", {error, s_ready, mem_we, busy});
        end
        do_start(16'd100);
        total++;
        if ({error, s_ready, busy} !== 3'b011) begin
            bad++; $display("FAIL len_100 got=%b exp=011", {error, s_ready, busy});
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_backpressure();
        // Handshake bytes 10,20,30 then checksum A0 (0x60 + 0xA0 = 0x100).
        logic [6:0]  pat;
        logic [7:0]  hs_data [4];
        logic        exp_we   [7];
        logic [31:0] exp_addr [7];
        logic [7:0]  exp_data [7];
        logic        exp_done [7];
        int j;
        pat = 7'b1011001; // bit i = s_valid in cycle i: 1,0,0,1,1,0,1
        hs_data[0] = 8'h10; hs_data[1] = 8'h20; hs_data[2] = 8'h30; hs_data[3] = 8'hA0;
        exp_we   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_addr = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd2, 32'd2};
        exp_data = '{8'h10, 8'h10, 8'h10, 8'h20, 8'h30, 8'h30, 8'h30};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        j = 0;
        do_start(16'd3);
        for (int i = 0; i < 7; i++) begin
            s_valid = pat[i];
            s_data  = pat[i] ? hs_data[j] : 8'hFF;
            if (pat[i]) j++;
            tick();
            total++;
            if ({mem_we, mem_waddr, mem_wdata, done} !== {exp_we[i], exp_addr[i], exp_data[i], exp_done[i]}) begin
                bad++; $display("FAIL bp_cycle%0d got we=%b a=%0d d=%h done=%b exp we=%b a=%0d d=%h done=%b",
                                i, mem_we, mem_waddr, mem_wdata, done, exp_we[i], exp_addr[i], exp_data[i], exp_done[i]);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_abort();
        do_start(16'd5);
        send_byte(8'h11);
        send_byte(8'h22);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({s_ready, busy, mem_we, cpu_run, error} !== 5'b00000) begin
            bad++; $display("FAIL abort_idle got=%b exp=00000", {s_ready, busy, mem_we, cpu_run, error});
        end
        do_start(16'd2);
        send_byte(8'h55);
        total++;
        if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'd0, 8'h55}) begin
            bad++; $display("FAIL restart_addr0 got we=%b a=%0d d=%h exp we=1 a=0 d=55", mem_we, mem_waddr, mem_wdata);
        end
        send_byte(8'hAA);
        send_byte(8'h01);
        total++;
        if ({done, cpu_run} !== 2'b11) begin
            bad++; $display("FAIL restart_run got=%b exp=11", {done, cpu_run});
        end
        abort = 1'b1; start = 1'b1; load_len = 16'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        total++;
        if ({busy, s_ready, cpu_run, error} !== 4'b0000) begin
            bad++; $display("FAIL abort_beats_start got=%b exp=0000", {busy, s_ready, cpu_run, error});
        end
    endtask

    task automatic test_async_reset();
        do_start(16'd4);
        send_byte(8'h34);
        // A write is pending on the outputs; pull reset between edges.
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, mem_we, cpu_run, busy, done, error, mem_waddr, mem_wdata} !== 46'd0) begin
            bad++; $display("FAIL async_reset got=%h exp=0", {s_ready, mem_we, cpu_run, busy, done, error, mem_waddr, mem_wdata});
        end
        #1 rst_n = 1'b1;
        tick();
        total++;
        if ({s_ready, busy, mem_we, cpu_run} !== 4'b0000) begin
            bad++; $display("FAIL post_reset_idle got=%b exp=0000", {s_ready, busy, mem_we, cpu_run});
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; load_len = '0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_length();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
